apb_sram_slave: RTL and testbench
=================================

# apb_sram_slave

Parametrised synchronous APB4 slave memory replacing the combinational async RAM slave. It adds clocked setup/access phasing, programmable wait states, byte strobes, read-data registration and decoded PSLVERR on out-of-range or misaligned accesses. It sits behind the APB master/decoder as a PSEL-selected peripheral and is the default memory slave for bus-level regression.

## Interface

- ADDR_WIDTH, 8: PADDR width in bits, byte address.
- DATA_WIDTH, 32: PWDATA/PRDATA width; legal values 8, 16, 32.
- DEPTH, 64: number of implemented words; word index ≥ DEPTH is an error.
- WAIT_STATES, 0: access-phase cycles with PREADY low before completion; range 0–15.

- PCLK  in  1  bus clock; all state changes on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte lanes; ignored on reads.
- PRDATA  out  DATA_WIDTH  read data, valid when PREADY & ~PWRITE.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response, valid only with PREADY.

## Operation

- Word index = PADDR[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; offset = low log2(DATA_WIDTH/8) bits.
- Error = (index ≥ DEPTH) | (offset ≠ 0). Decoded at setup, held for the transfer.
- FSM states IDLE, SETUP, ACCESS:
  - IDLE → SETUP on PSEL & ~PENABLE.
  - SETUP → ACCESS unconditionally; captures address, direction, error flag; on legal read loads PRDATA from array.
  - ACCESS: wait counter increments each cycle while < WAIT_STATES; on completion → SETUP if PSEL & ~PENABLE (back-to-back), else IDLE.
  - PSEL low in SETUP/ACCESS (protocol abort) → IDLE, no write, counter cleared.
  - PENABLE without prior setup: ignored, remain IDLE, PREADY stays 0.
- Write commits only in the completing cycle, only if no error; each byte lane written where PSTRB bit = 1; PSTRB = 0 is a legal no-op with PSLVERR = 0.
- Errored write: array unchanged. Errored read: PRDATA driven 0.
- PRDATA holds its last value between transfers; no Z driving.
- Array contents not reset; reset clears FSM, counter, PRDATA only.

## Timing

- Reset values: PRDATA = 0, PREADY = 0, PSLVERR = 0, state IDLE, counter 0.
- PREADY = (state == ACCESS) & PSEL & PENABLE & (counter == WAIT_STATES), combinational from registered state.
- PSLVERR = PREADY & captured error; 0 at all other times.
- Zero-wait transfer: 2 cycles (setup + access); each wait state adds 1 cycle.
- Read data registered at SETUP edge; valid throughout ACCESS, including wait states.
- Write-then-read of same word back-to-back returns the new data (write commits at end of access, read samples at following setup edge).
- PRESETn asserted mid-transfer: immediate return to IDLE, PREADY/PSLVERR drop asynchronously, pending write discarded.

## Structure

- Shared package apb_pkg: apb_state_e (IDLE, SETUP, ACCESS), APB_OKAY/APB_ERR response constants, strobe-width helper function.
- Sub-module apb_sram_array: DEPTH×DATA_WIDTH synchronous byte-enable write, synchronous read port; no reset.
- Top contains FSM, wait counter, address decode, response logic.

## Test plan

- Reset: PRESETn low → PRDATA = 0, PREADY = 0, PSLVERR = 0; release, idle bus → outputs unchanged.
- Zero-wait write 0xDEADBEEF to 0x10, PSTRB = 0xF, then read 0x10 → PREADY high in second cycle of each transfer, PRDATA = 0xDEADBEEF, PSLVERR = 0.
- WAIT_STATES = 3: read → PREADY low for 3 access cycles, high on 4th; PRDATA stable from first access cycle.
- Byte strobes: write 0xAABBCCDD with PSTRB = 0x5 over 0x00000000 → readback 0x00BB00DD.
- Errors (DEPTH = 64, 32-bit): write to 0x100 and read 0x02 → PSLVERR = 1 with PREADY, PRDATA = 0, array unchanged on subsequent read of 0x00.
- Abort/reset: drop PSEL during wait states, and separately pulse PRESETn in ACCESS → no write committed, FSM IDLE, next transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions for the SRAM slave.
//   apb_state_e : transfer phase (IDLE, SETUP, ACCESS)
//   APB_OKAY/APB_ERR : values driven on PSLVERR
//   strb_width() : number of byte lanes for a given data width
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam logic APB_OKAY = 1'b0;
  localparam logic APB_ERR  = 1'b1;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_sram_array.sv
// Word-organised SRAM with a byte-enable write port and a registered read port.
// Contents are deliberately not reset.
//   clk    : clock
//   we     : write enable, waddr/wstrb/wdata qualify it
//   re     : read enable, loads rdata from raddr on the rising edge
//   rdata  : registered read data, holds between reads
module apb_sram_array
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int NB         = strb_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [NB-1:0]         wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_sram_slave.sv
// APB4 slave memory with programmable wait states, byte strobes, registered
// read data and PSLVERR on out-of-range or misaligned addresses.
//   PCLK, PRESETn          : clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE  : APB control
//   PADDR, PWDATA, PSTRB   : byte address, write data, write byte lanes
//   PRDATA, PREADY, PSLVERR: read data, completion, error response
module apb_sram_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic                          PSEL,
  input  logic                          PENABLE,
  input  logic                          PWRITE,
  input  logic [ADDR_WIDTH-1:0]         PADDR,
  input  logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH/8-1:0]       PSTRB,
  output logic [DATA_WIDTH-1:0]         PRDATA,
  output logic                          PREADY,
  output logic                          PSLVERR
);

  localparam int NB  = strb_width(DATA_WIDTH);
  localparam int OFF = (NB > 1) ? $clog2(NB) : 0;
  localparam int MAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << OFF) - 1);

  apb_state_e      state_q, state_d, state_cur;
  logic [3:0]      cnt_q, cnt_d;
  logic [MAW-1:0]  addr_q, addr_d;
  logic            write_q, write_d;
  logic            err_q, err_d;
  logic            rd_valid_q, rd_valid_d;

  logic [31:0]           idx_wide;
  logic [MAW-1:0]        mem_idx;
  logic                  decode_err;
  logic                  pready;
  logic                  rd_en;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Address decode on the live bus; only sampled on the setup edge.
  assign idx_wide   = 32'(PADDR >> OFF);
  assign mem_idx    = PADDR[OFF +: MAW];
  assign decode_err = (idx_wide >= 32'(DEPTH)) || ((PADDR & OFF_MASK) != '0);

  // Completion is combinational from registered state so that PREADY/PSLVERR
  // fall immediately when PSEL drops or reset asserts.
  assign pready = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == WS);

  always_comb begin
    state_cur  = state_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    err_d      = err_q;
    rd_valid_d = rd_valid_q;
    rd_en      = 1'b0;
    mem_we     = 1'b0;

    // The bus setup cycle is recognised combinationally so that capture
    // happens on the edge closing it; a zero-wait transfer is then two cycles.
    if ((state_q == IDLE) && PSEL && !PENABLE) begin
      state_cur = SETUP;
    end

    case (state_cur)
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
        addr_d  = mem_idx;
        write_d = PWRITE;
        err_d   = decode_err;
        if (!PWRITE) begin
          rd_en      = !decode_err;
          rd_valid_d = !decode_err;  // errored read shows zero on PRDATA
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q < WS) begin
          cnt_d = cnt_q + 4'd1;
        end else if (pready) begin
          mem_we  = write_q && !err_q;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  apb_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (MAW),
    .NB         (NB)
  ) u_array (
    .clk   (PCLK),
    .we    (mem_we),
    .waddr (addr_q),
    .wstrb (PSTRB),
    .wdata (PWDATA),
    .re    (rd_en),
    .raddr (mem_idx),
    .rdata (mem_rdata)
  );

  // The array read register has no reset; rd_valid_q gates it so PRDATA is
  // zero after reset and after an errored read, and holds otherwise.
  assign PRDATA  = rd_valid_q ? mem_rdata : '0;
  assign PREADY  = pready;
  assign PSLVERR = pready ? (err_q ? APB_ERR : APB_OKAY) : APB_OKAY;

endmodule

// File: tb/tb_apb_sram_slave.sv
module tb_apb_sram_slave;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [3:0]      pstrb;
  logic            psel_v    [2];
  logic            pready_v  [2];
  logic            pslverr_v [2];
  logic [DW-1:0]   prdata_v  [2];

  apb_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_v[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata_v[0]), .PREADY(pready_v[0]), .PSLVERR(pslverr_v[0]));

  apb_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .PRESETn(rst_n), .PSEL(psel_v[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata_v[1]), .PREADY(pready_v[1]), .PSLVERR(pslverr_v[1]));

  int n_vec = 0;
  int n_err = 0;

  // Reference: word-addressed memory per DUT and the last value PRDATA should show.
  logic [31:0] ref_mem [2][DEPTH];
  logic [31:0] last_rd [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic bit addr_err(input logic [AW-1:0] a);
    int ai;
    ai = int'(a);
    return ((ai % 4) != 0) || ((ai / 4) >= DEPTH);
  endfunction

  // Full transfer; called at 1 time unit after a rising edge, returns likewise.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a,
                      input logic [31:0] wd, input logic [3:0] st, output logic [31:0] rd);
    bit          e;
    bit          done;
    int          w;
    int          idx;
    logic [31:0] exp_rd;
    e   = addr_err(a);
    idx = int'(a) / 4;
    if (wr)     exp_rd = last_rd[d];
    else if (e) exp_rd = 32'h0;
    else        exp_rd = ref_mem[d][idx];

    psel_v[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge clk);
    chk("setup_rdy", 32'(pready_v[d]), 32'h0);
    @(posedge clk); #1 penable = 1'b1;
    done = 1'b0;
    w    = 0;
    while (!done && w < 40) begin
      @(negedge clk);
      chk(wr ? "wr_prdata" : "rd_prdata", prdata_v[d], exp_rd);
      if (pready_v[d]) done = 1'b1;
      else             w++;
    end
    if (!done) begin
      chk("timeout", 32'h0, 32'h1);
    end else begin
      chk("wait_cnt", 32'(w), 32'(ws_of(d)));
      chk("pslverr", 32'(pslverr_v[d]), 32'(e));
    end
    rd = prdata_v[d];
    @(posedge clk); #1;
    psel_v[d] = 1'b0; penable = 1'b0;

    if (!e) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) ref_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        last_rd[d] = ref_mem[d][idx];
      end
    end else if (!wr) begin
      last_rd[d] = 32'h0;
    end
    chk("hold", prdata_v[d], last_rd[d]);
    $display("xfer dut%0d %s addr=%h wdata=%h strb=%h rdata=%h err=%0d waits=%0d",
             d, wr ? "WR" : "RD", a, wd, st, rd, e, w);
  endtask

  // Transfer cut short after k access cycles, by PSEL drop or by reset pulse.
  task automatic xfer_abort(input int d, input bit wr, input logic [AW-1:0] a,
                            input logic [31:0] wd, input int k, input bit use_rst);
    bit e;
    e = addr_err(a);
    psel_v[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    repeat (k) begin
      @(posedge clk); #1;
    end
    if (k == ws_of(d)) begin
      chk("ab_rdy_pre", 32'(pready_v[d]), 32'h1);
      chk("ab_err_pre", 32'(pslverr_v[d]), 32'(e));
    end else begin
      chk("ab_rdy_pre", 32'(pready_v[d]), 32'h0);
    end
    if (use_rst) begin
      rst_n = 1'b0;
      #1;
      for (int d2 = 0; d2 < 2; d2++) begin
        chk("arst_rdy", 32'(pready_v[d2]), 32'h0);
        chk("arst_err", 32'(pslverr_v[d2]), 32'h0);
        chk("arst_prdata", prdata_v[d2], 32'h0);
        last_rd[d2] = 32'h0;
      end
      @(negedge clk);
      rst_n = 1'b1; psel_v[d] = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
    end else begin
      psel_v[d] = 1'b0; penable = 1'b0;
      @(posedge clk); #1;
      chk("abort_rdy", 32'(pready_v[d]), 32'h0);
    end
    $display("abort dut%0d %s addr=%h wdata=%h after=%0d by=%s",
             d, wr ? "WR" : "RD", a, wd, k, use_rst ? "reset" : "psel");
  endtask

  initial begin
    logic [31:0]   rd;
    logic [AW-1:0] a;
    bit            wr;
    int            d;

    rst_n = 1'b0; psel_v[0] = 1'b0; psel_v[1] = 1'b0;
    penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_prdata", prdata_v[i], 32'h0);
      chk("rst_rdy", 32'(pready_v[i]), 32'h0);
      chk("rst_err", 32'(pslverr_v[i]), 32'h0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("idle_prdata", prdata_v[i], 32'h0);
      chk("idle_rdy", 32'(pready_v[i]), 32'h0);
      chk("idle_err", 32'(pslverr_v[i]), 32'h0);
    end

    // PENABLE with no preceding setup phase must be ignored.
    @(posedge clk); #1 psel_v[0] = 1'b1; penable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("nosetup_rdy", 32'(pready_v[0]), 32'h0);
    end
    @(posedge clk); #1 psel_v[0] = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

    // Give every word a known value.
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++)
        xfer(i, 1'b1, AW'(j * 4), $urandom, 4'hF, rd);

    // Basic write/read on both wait-state settings.
    for (int i = 0; i < 2; i++) begin
      xfer(i, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, rd);
      xfer(i, 1'b0, 12'h010, 32'h0, 4'h0, rd);
      chk("dir_rd", rd, 32'hDEADBEEF);
    end

    // Byte strobes over a zeroed word.
    xfer(0, 1'b1, 12'h000, 32'h0, 4'hF, rd);
    xfer(0, 1'b1, 12'h000, 32'hAABBCCDD, 4'h5, rd);
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd);
    chk("strb_rd", rd, 32'h00BB00DD);
    xfer(0, 1'b1, 12'h000, 32'h99999999, 4'h0, rd);
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd);
    chk("strb0_rd", rd, 32'h00BB00DD);

    // Out-of-range write (aliases word 0 if not gated) and misaligned read.
    xfer(0, 1'b1, 12'h100, 32'h12345678, 4'hF, rd);
    xfer(0, 1'b0, 12'h002, 32'h0, 4'h0, rd);
    chk("err_rd", rd, 32'h0);
    xfer(0, 1'b0, 12'h000, 32'h0, 4'h0, rd);
    chk("err_keep", rd, 32'h00BB00DD);
    xfer(1, 1'b1, 12'h100, 32'h12345678, 4'hF, rd);
    xfer(1, 1'b0, 12'h003, 32'h0, 4'h0, rd);
    chk("err_rd3", rd, 32'h0);

    // Abort by PSEL drop and by reset; the write must not land.
    xfer(1, 1'b1, 12'h020, 32'h11111111, 4'hF, rd);
    xfer_abort(1, 1'b1, 12'h020, 32'h22222222, 1, 1'b0);
    xfer(1, 1'b0, 12'h020, 32'h0, 4'h0, rd);
    chk("psel_abort_keep", rd, 32'h11111111);
    xfer_abort(1, 1'b1, 12'h020, 32'h33333333, 3, 1'b1);
    xfer(1, 1'b0, 12'h020, 32'h0, 4'h0, rd);
    chk("rst_abort_keep", rd, 32'h11111111);
    xfer_abort(1, 1'b1, 12'h100, 32'h44444444, 3, 1'b1);
    chk("rst_prdata0", prdata_v[0], 32'h0);

    // Back-to-back write then read of the same word.
    for (int i = 0; i < 2; i++) begin
      xfer(i, 1'b1, 12'h0F0, 32'hC0FFEE00 + 32'(i), 4'hF, rd);
      xfer(i, 1'b0, 12'h0F0, 32'h0, 4'h0, rd);
      chk("b2b_rd", rd, 32'hC0FFEE00 + 32'(i));
    end

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = AW'($urandom_range(0, 4095));
      else                           a = AW'($urandom_range(0, DEPTH - 1) * 4);
      xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)), rd);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
